// File: rtl/trigger_pkg.sv
// trigger_pkg: shared FSM state encoding and default sizing for the trigger pulse generator.
package trigger_pkg;
    localparam int CNT_W_DEF = 32;
    localparam int SYNC_STAGES_DEF = 2;
    typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer plus history flop with selectable-polarity edge flag.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic rising_sel,
    output logic edge_flag
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   cur;

    assign cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= cur;
        end
    end

    assign edge_flag = rising_sel ? (cur & ~hist_q) : (~cur & hist_q);
endmodule

// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen: one-shot armed trigger -> programmable delay -> programmable-width pulse.
// Outputs are registered views of the FSM state, so they trail the state register by one clk.
module trigger_pulse_gen
    import trigger_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic             cfg_rising,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic             arm,
    input  logic             abort,
    output logic             pulse_out,
    output logic             armed,
    output logic             busy,
    output logic             done
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, delay_q, width_q, width_eff;
    logic             rising_q, edge_flag, fin_q, fin_d;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (trig_in),
        .rising_sel (rising_q),
        .edge_flag  (edge_flag)
    );

    assign width_eff = (width_q == '0) ? CNT_W'(1) : width_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = 1'b0;
        unique case (state_q)
            IDLE:  state_d = arm ? ARMED : IDLE;
            ARMED: if (edge_flag) begin
                state_d = (delay_q != '0) ? DELAY : PULSE;
                cnt_d   = (delay_q != '0) ? delay_q : width_eff;
            end
            DELAY: begin
                state_d = (cnt_q == CNT_W'(1)) ? PULSE : DELAY;
                cnt_d   = (cnt_q == CNT_W'(1)) ? width_eff : cnt_q - 1'b1;
            end
            PULSE: begin
                state_d = (cnt_q == CNT_W'(1)) ? IDLE : PULSE;
                cnt_d   = cnt_q - 1'b1;
                fin_d   = (cnt_q == CNT_W'(1));
            end
            default: state_d = IDLE;
        endcase
        // abort overrides everything, including arm and a coincident edge
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            fin_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            delay_q   <= '0;
            width_q   <= '0;
            rising_q  <= 1'b0;
            pulse_out <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            if (state_q == IDLE && arm && !abort) begin
                delay_q  <= cfg_delay;
                width_q  <= cfg_width;
                rising_q <= cfg_rising;
            end
            pulse_out <= (state_q == PULSE) && !abort;
            armed     <= (state_q == ARMED) && !abort;
            busy      <= (state_q != IDLE) && !abort;
            done      <= fin_q && !abort;
        end
    end
endmodule

// File: tb/tb_trigger_pulse_gen.sv
// tb_trigger_pulse_gen: directed scenarios with a pulse scoreboard checked by a negedge monitor.
module tb_trigger_pulse_gen;
    typedef struct {
        int   start;
        int   width;
        logic dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig_in = 1'b0;
    logic        cfg_rising = 1'b0;
    logic [31:0] cfg_delay = '0;
    logic [31:0] cfg_width = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        pulse_out, armed, busy, done;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   p_start = 0;
    int   p_len = 0;
    logic prev_p = 1'b0;
    exp_t sb[$];
    exp_t e;

    trigger_pulse_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_in    (trig_in),
        .cfg_rising (cfg_rising),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .arm        (arm),
        .abort      (abort),
        .pulse_out  (pulse_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // pulse monitor: measures each pulse and matches it against the oldest expectation
    always @(negedge clk) begin
        if (pulse_out && !prev_p) begin
            p_start = cyc;
            p_len = 0;
        end
        if (pulse_out) p_len++;
        if (prev_p && !pulse_out) begin
            chk("pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pulse_start", p_start, e.start);
                chk("pulse_width", p_len, e.width);
                chk("done_at_fall", done, e.dn);
            end
        end else begin
            chk("done_quiet", done, 0);
        end
        prev_p = pulse_out;
    end

    task automatic do_arm(input logic r, input logic idle, input logic [31:0] d, input logic [31:0] w);
        trig_in = idle;
        repeat (4) @(negedge clk);
        cfg_rising = r;
        cfg_delay = d;
        cfg_width = w;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        @(negedge clk);
        chk("armed_after_arm", armed, 1);
        chk("busy_after_arm", busy, 1);
    endtask

    task automatic fire(input logic v, input int d, input int w, input logic dn);
        trig_in = v;
        sb.push_back('{start: cyc + 4 + d, width: w, dn: dn});
    endtask

    task automatic settle(input int lim);
        int k = 0;
        while ((sb.size() != 0 || busy) && k < lim) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("settle_in_time", 32'(k < lim), 1);
        chk("busy_after_done", busy, 0);
        chk("armed_after_done", armed, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pulse_out", pulse_out, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        // delay 10 width 4, with a stray arm (new width) ignored during DELAY
        do_arm(1'b1, 1'b0, 10, 4);
        fire(1'b1, 10, 4, 1'b1);
        repeat (5) @(negedge clk);
        cfg_width = 9;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        settle(200);

        // delay 0 width 0 behaves as a single-cycle pulse at T+1
        do_arm(1'b1, 1'b0, 0, 0);
        fire(1'b1, 0, 1, 1'b1);
        settle(200);

        // falling-edge select: rise ignored, fall fires, second edge in DELAY ignored
        do_arm(1'b0, 1'b0, 20, 3);
        trig_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("armed_after_rise", armed, 1);
        fire(1'b0, 20, 3, 1'b1);
        repeat (10) @(negedge clk);
        trig_in = 1'b1;
        repeat (4) @(negedge clk);
        trig_in = 1'b0;
        settle(200);

        // cfg_delay changed while ARMED has no effect
        do_arm(1'b1, 1'b0, 10, 4);
        cfg_delay = 50;
        repeat (2) @(negedge clk);
        fire(1'b1, 10, 4, 1'b1);
        settle(200);

        // abort in the second high cycle of a long pulse
        do_arm(1'b1, 1'b0, 5, 100);
        fire(1'b1, 5, 2, 1'b0);
        for (int k = 0; k < 50 && !pulse_out; k++) @(negedge clk);
        chk("abort_pulse_seen", pulse_out, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pulse_low", pulse_out, 0);
        chk("abort_armed", armed, 0);
        chk("abort_busy", busy, 0);
        settle(50);

        // reset in DELAY, then an edge without re-arm must not produce a pulse
        do_arm(1'b1, 1'b0, 30, 4);
        trig_in = 1'b1;
        repeat (8) @(negedge clk);
        chk("busy_in_delay", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_pulse_out", pulse_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_armed", armed, 0);
        @(negedge clk);
        rst_n = 1'b1;
        trig_in = 1'b0;
        repeat (4) @(negedge clk);
        trig_in = 1'b1;
        repeat (60) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_armed", armed, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
